// File: rtl/seg7_scan_reader_pkg.sv
// Shared seven-segment encodings (gfedcba, active-high) and scan reader types.
// Used by both the BCD-to-segment driver and the segment-to-BCD reader.
package seg7_scan_reader_pkg;

    localparam logic [6:0] SEG_0 = 7'h3F;
    localparam logic [6:0] SEG_1 = 7'h06;
    localparam logic [6:0] SEG_2 = 7'h5B;
    localparam logic [6:0] SEG_3 = 7'h4F;
    localparam logic [6:0] SEG_4 = 7'h66;
    localparam logic [6:0] SEG_5 = 7'h6D;
    localparam logic [6:0] SEG_6 = 7'h7D;
    localparam logic [6:0] SEG_7 = 7'h07;
    localparam logic [6:0] SEG_8 = 7'h7F;
    localparam logic [6:0] SEG_9 = 7'h6F;
    localparam logic [6:0] SEG_F = 7'h71;
    localparam logic [6:0] SEG_BLANK = 7'h00;

    localparam logic [3:0] INVALID_BCD = 4'hF;

    typedef enum logic {
        COLLECT = 1'b0,
        PUBLISH = 1'b1
    } state_t;

    function automatic logic [6:0] bcd_to_seg(input logic [3:0] bcd);
        logic [6:0] s;
        s = SEG_F;
        case (bcd)
            4'd0: s = SEG_0;
            4'd1: s = SEG_1;
            4'd2: s = SEG_2;
            4'd3: s = SEG_3;
            4'd4: s = SEG_4;
            4'd5: s = SEG_5;
            4'd6: s = SEG_6;
            4'd7: s = SEG_7;
            4'd8: s = SEG_8;
            4'd9: s = SEG_9;
            default: s = SEG_F;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/seg7_to_bcd.sv
// Combinational reverse lookup: segment pattern to BCD digit plus error flag.
// Anything outside the ten decimal glyphs maps to INVALID_BCD with err set.
module seg7_to_bcd
    import seg7_scan_reader_pkg::*;
(
    input  logic [6:0] seg,
    output logic [3:0] bcd,
    output logic       err
);

    always_comb begin
        bcd = INVALID_BCD;
        err = 1'b0;
        case (seg)
            SEG_0: bcd = 4'd0;
            SEG_1: bcd = 4'd1;
            SEG_2: bcd = 4'd2;
            SEG_3: bcd = 4'd3;
            SEG_4: bcd = 4'd4;
            SEG_5: bcd = 4'd5;
            SEG_6: bcd = 4'd6;
            SEG_7: bcd = 4'd7;
            SEG_8: bcd = 4'd8;
            SEG_9: bcd = 4'd9;
            default: begin
                bcd = INVALID_BCD;
                err = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/seg7_scan_reader.sv
// Receive side of a scanned 7-segment display: synchronise, qualify for
// stability, decode each strobed digit and publish complete frames.
module seg7_scan_reader
    import seg7_scan_reader_pkg::*;
#(
    parameter int NUM_DIGITS     = 2,
    parameter int STABLE_CYCLES  = 4,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [6:0]              seg_in,
    input  logic [NUM_DIGITS-1:0]   digit_sel,
    output logic [4*NUM_DIGITS-1:0] digits_out,
    output logic [NUM_DIGITS-1:0]   digit_err,
    output logic                    frame_valid,
    output logic                    frame_timeout
);

    localparam int CW = $clog2(STABLE_CYCLES + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int SW = 7 + NUM_DIGITS;
    localparam logic [CW-1:0] STABLE_MAX = CW'(STABLE_CYCLES);
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);

    logic [6:0]            seg_m, seg_s;
    logic [NUM_DIGITS-1:0] sel_m, sel_s;
    logic [SW-1:0]         sample, prev;
    logic [CW-1:0]         cnt, cnt_nxt;
    logic                  armed, arm_eff, same, hit;
    logic                  sel_ok, accept;
    logic [3:0]            dec_bcd;
    logic                  dec_err;

    logic [NUM_DIGITS-1:0][3:0] shadow;
    logic [NUM_DIGITS-1:0]      shadow_err;
    logic [NUM_DIGITS-1:0]      seen, seen_nxt;
    logic [TW-1:0]              tcnt, tcnt_nxt;
    logic                       to_fire, pub;
    state_t                     state, state_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg_m <= '0;
            seg_s <= '0;
            sel_m <= '0;
            sel_s <= '0;
        end else begin
            seg_m <= seg_in;
            seg_s <= seg_m;
            sel_m <= digit_sel;
            sel_s <= sel_m;
        end
    end

    assign sample = {seg_s, sel_s};
    assign same   = (sample == prev);
    assign sel_ok = (sel_s != '0) && ((sel_s & (sel_s - 1'b1)) == '0);

    // A changed sample restarts the run and re-arms in the same cycle,
    // so STABLE_CYCLES==1 accepts on the very first differing sample.
    always_comb begin
        cnt_nxt = CW'(1);
        arm_eff = 1'b1;
        if (same) begin
            cnt_nxt = (cnt == STABLE_MAX) ? cnt : cnt + CW'(1);
            arm_eff = armed;
        end
    end

    assign hit    = arm_eff && (cnt_nxt == STABLE_MAX);
    assign accept = hit && sel_ok;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev  <= '0;
            cnt   <= '0;
            armed <= 1'b1;
        end else begin
            prev  <= sample;
            cnt   <= cnt_nxt;
            armed <= arm_eff && !hit;
        end
    end

    seg7_to_bcd u_dec (
        .seg (seg_s),
        .bcd (dec_bcd),
        .err (dec_err)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= COLLECT;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        seen_nxt  = seen;
        tcnt_nxt  = tcnt;
        to_fire   = 1'b0;
        pub       = 1'b0;
        case (state)
            COLLECT: begin
                if (accept) begin
                    seen_nxt = seen | sel_s;
                    tcnt_nxt = '0;
                end else if (seen != '0) begin
                    if (tcnt == TO_LAST) begin
                        to_fire  = 1'b1;
                        seen_nxt = '0;
                        tcnt_nxt = '0;
                    end else begin
                        tcnt_nxt = tcnt + TW'(1);
                    end
                end
                if (&seen_nxt) begin
                    state_nxt = PUBLISH;
                end
            end
            PUBLISH: begin
                // Acceptance landing here seeds the next frame.
                pub       = 1'b1;
                seen_nxt  = accept ? sel_s : '0;
                tcnt_nxt  = '0;
                state_nxt = COLLECT;
            end
            default: state_nxt = COLLECT;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow     <= '0;
            shadow_err <= '0;
            seen       <= '0;
            tcnt       <= '0;
        end else begin
            seen <= seen_nxt;
            tcnt <= tcnt_nxt;
            for (int i = 0; i < NUM_DIGITS; i++) begin
                if (accept && sel_s[i]) begin
                    shadow[i]     <= dec_bcd;
                    shadow_err[i] <= dec_err;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            digits_out    <= '0;
            digit_err     <= '0;
            frame_valid   <= 1'b0;
            frame_timeout <= 1'b0;
        end else begin
            frame_valid   <= pub;
            frame_timeout <= to_fire;
            if (pub) begin
                digits_out <= shadow;
                digit_err  <= shadow_err;
            end
        end
    end

endmodule

// File: tb/tb_seg7_scan_reader.sv
// Directed self-checking bench for seg7_scan_reader (2 digits, defaults).
module tb_seg7_scan_reader;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [6:0] seg_in = '0;
    logic [1:0] digit_sel = '0;
    logic [7:0] digits_out;
    logic [1:0] digit_err;
    logic       frame_valid;
    logic       frame_timeout;

    int checks = 0;
    int fails = 0;
    int cyc = 0;
    int fv_cnt = 0;
    int to_cnt = 0;
    int to_cyc = 0;

    seg7_scan_reader #(
        .NUM_DIGITS     (2),
        .STABLE_CYCLES  (4),
        .TIMEOUT_CYCLES (1024)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .seg_in        (seg_in),
        .digit_sel     (digit_sel),
        .digits_out    (digits_out),
        .digit_err     (digit_err),
        .frame_valid   (frame_valid),
        .frame_timeout (frame_timeout)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (frame_valid) fv_cnt = fv_cnt + 1;
        if (frame_timeout) begin
            to_cnt = to_cnt + 1;
            to_cyc = cyc;
        end
    end

    task automatic drive(input logic [1:0] s, input logic [6:0] p,
                         input int n);
        digit_sel = s;
        seg_in = p;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [6:0] d0, input logic [6:0] d1);
        drive(2'b01, d0, 10);
        drive(2'b10, d1, 10);
        drive(2'b00, 7'h00, 5);
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        #1;
        checks++;
        if (digits_out !== 8'h00) begin
            fails++;
            $display("FAIL reset_digits: got %h want 00", digits_out);
        end
        checks++;
        if (digit_err !== 2'b00) begin
            fails++;
            $display("FAIL reset_err: got %b want 00", digit_err);
        end
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (frame_valid !== 1'b0 || frame_timeout !== 1'b0) begin
            fails++;
            $display("FAIL reset_pulses: fv %b to %b want 0 0",
                     frame_valid, frame_timeout);
        end
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_basic;
        int fv0;
        fv0 = fv_cnt;
        send_frame(7'h4F, 7'h6D);
        checks++;
        if (fv_cnt - fv0 !== 1) begin
            fails++;
            $display("FAIL basic_fv: got %0d pulses want 1", fv_cnt - fv0);
        end
        checks++;
        if (digits_out !== 8'h53) begin
            fails++;
            $display("FAIL basic_digits: got %h want 53", digits_out);
        end
        checks++;
        if (digit_err !== 2'b00) begin
            fails++;
            $display("FAIL basic_err: got %b want 00", digit_err);
        end
    endtask

    task automatic test_glitch;
        int fv0;
        fv0 = fv_cnt;
        drive(2'b01, 7'h06, 10);
        drive(2'b01, 7'h5B, 3);
        drive(2'b10, 7'h07, 10);
        drive(2'b00, 7'h00, 5);
        checks++;
        if (fv_cnt - fv0 !== 1) begin
            fails++;
            $display("FAIL glitch_fv: got %0d pulses want 1", fv_cnt - fv0);
        end
        checks++;
        if (digits_out !== 8'h71) begin
            fails++;
            $display("FAIL glitch_digits: got %h want 71", digits_out);
        end
    endtask

    task automatic test_invalid;
        int fv0;
        fv0 = fv_cnt;
        send_frame(7'h71, 7'h00);
        checks++;
        if (fv_cnt - fv0 !== 1) begin
            fails++;
            $display("FAIL invalid_fv: got %0d pulses want 1", fv_cnt - fv0);
        end
        checks++;
        if (digits_out !== 8'hFF) begin
            fails++;
            $display("FAIL invalid_digits: got %h want FF", digits_out);
        end
        checks++;
        if (digit_err !== 2'b11) begin
            fails++;
            $display("FAIL invalid_err: got %b want 11", digit_err);
        end
    endtask

    task automatic test_bad_strobe;
        int fv0, to0;
        fv0 = fv_cnt;
        to0 = to_cnt;
        drive(2'b11, 7'h3F, 20);
        drive(2'b00, 7'h06, 20);
        checks++;
        if (fv_cnt - fv0 !== 0) begin
            fails++;
            $display("FAIL strobe_fv: got %0d pulses want 0", fv_cnt - fv0);
        end
        checks++;
        if (to_cnt - to0 !== 0) begin
            fails++;
            $display("FAIL strobe_to: got %0d pulses want 0", to_cnt - to0);
        end
        checks++;
        if (digits_out !== 8'hFF || digit_err !== 2'b11) begin
            fails++;
            $display("FAIL strobe_hold: got %h/%b want FF/11",
                     digits_out, digit_err);
        end
    endtask

    task automatic test_overwrite;
        int fv0;
        fv0 = fv_cnt;
        drive(2'b01, 7'h3F, 10);
        drive(2'b01, 7'h4F, 10);
        drive(2'b10, 7'h5B, 10);
        drive(2'b00, 7'h00, 5);
        checks++;
        if (fv_cnt - fv0 !== 1) begin
            fails++;
            $display("FAIL overwrite_fv: got %0d pulses want 1",
                     fv_cnt - fv0);
        end
        checks++;
        if (digits_out !== 8'h23 || digit_err !== 2'b00) begin
            fails++;
            $display("FAIL overwrite_digits: got %h/%b want 23/00",
                     digits_out, digit_err);
        end
    endtask

    task automatic test_timeout;
        int fv0, to0, k;
        fv0 = fv_cnt;
        to0 = to_cnt;
        k = cyc;
        drive(2'b01, 7'h3F, 10);
        drive(2'b00, 7'h00, 1040);
        checks++;
        if (to_cnt - to0 !== 1) begin
            fails++;
            $display("FAIL timeout_pulses: got %0d want 1", to_cnt - to0);
        end
        checks++;
        if (to_cyc - k !== 1030) begin
            fails++;
            $display("FAIL timeout_time: got %0d want 1030", to_cyc - k);
        end
        checks++;
        if (fv_cnt - fv0 !== 0) begin
            fails++;
            $display("FAIL timeout_fv: got %0d pulses want 0", fv_cnt - fv0);
        end
        checks++;
        if (digits_out !== 8'h23) begin
            fails++;
            $display("FAIL timeout_digits: got %h want 23", digits_out);
        end
    endtask

    task automatic test_reset_midframe;
        int fv0;
        drive(2'b01, 7'h66, 10);
        rst_n = 1'b0;
        #1;
        checks++;
        if (digits_out !== 8'h00 || digit_err !== 2'b00 ||
            frame_valid !== 1'b0 || frame_timeout !== 1'b0) begin
            fails++;
            $display("FAIL midreset_outs: got %h/%b/%b/%b want 00/00/0/0",
                     digits_out, digit_err, frame_valid, frame_timeout);
        end
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        fv0 = fv_cnt;
        drive(2'b10, 7'h7F, 10);
        drive(2'b00, 7'h00, 10);
        checks++;
        if (fv_cnt - fv0 !== 0) begin
            fails++;
            $display("FAIL midreset_partial: got %0d pulses want 0",
                     fv_cnt - fv0);
        end
        drive(2'b01, 7'h66, 10);
        drive(2'b00, 7'h00, 5);
        checks++;
        if (fv_cnt - fv0 !== 1) begin
            fails++;
            $display("FAIL midreset_fv: got %0d pulses want 1", fv_cnt - fv0);
        end
        checks++;
        if (digits_out !== 8'h84 || digit_err !== 2'b00) begin
            fails++;
            $display("FAIL midreset_digits: got %h/%b want 84/00",
                     digits_out, digit_err);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_glitch();
        test_invalid();
        test_bad_strobe();
        test_overwrite();
        test_timeout();
        test_reset_midframe();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 checks, fails);
        $finish;
    end

endmodule
